// File: rtl/mdio_link_monitor.sv
`default_nettype none
//==============================================================================
// Module   : mdio_link_monitor
// Function : Autonomous clause-22 PHY status poller. Reads BMSR (link) and the
//            PHY-specific status register (speed/duplex) through the MDIO
//            controller's command/response handshake and presents registered
//            link status to the MAC speed-select logic.
// Options  : MDIO_PHY_INIT_EN - issue one BMCR write of INIT_BMCR after reset,
//            before periodic polling begins.
// Revision : 1.0 - initial release
//==============================================================================
module mdio_link_monitor #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [4:0]  PSSR_ADDR     = 5'h11,
    parameter int unsigned POLL_INTERVAL = 1250000,
    parameter int unsigned RSP_TIMEOUT   = 4096,
    parameter logic [15:0] INIT_BMCR     = 16'h9140
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_now,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [4:0]  cmd_phyaddr,
    output logic [4:0]  cmd_regaddr,
    output logic [15:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_rdata,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        full_duplex,
    output logic        status_valid,
    output logic        link_change,
    output logic        timeout_err,
    output logic        busy
);

    localparam int              c_IW        = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int              c_TW        = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [c_IW-1:0] c_RELOAD    = c_IW'(POLL_INTERVAL - 1);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(RSP_TIMEOUT - 1);
    localparam logic [4:0]      c_BMSR_ADDR = 5'd1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
`ifdef MDIO_PHY_INIT_EN
        S_INIT_REQ  = 3'd1,
        S_INIT_WAIT = 3'd2,
`endif
        S_BMSR_REQ  = 3'd3,
        S_BMSR_WAIT = 3'd4,
        S_PSSR_REQ  = 3'd5,
        S_PSSR_WAIT = 3'd6,
        S_UPDATE    = 3'd7
    } state_t;

    state_t          r_state;
    logic [c_IW-1:0] r_interval;
    logic [c_TW-1:0] r_wait_cnt;
    logic            r_poll_pending;
    logic            r_cmd_valid;
    logic [4:0]      r_cmd_phyaddr;
    logic [4:0]      r_cmd_regaddr;
    logic            r_bmsr_link;
    logic            r_pssr_usable;
    logic [1:0]      r_pssr_speed;
    logic            r_pssr_duplex;
    logic            r_link_up;
    logic [1:0]      r_speed;
    logic            r_full_duplex;
    logic            r_status_valid;
    logic            r_link_change;
    logic            r_timeout_err;

    logic            w_init_done;
    logic            w_init_end;
    logic            w_poll_start;
    logic            w_wait_expired;
    logic            w_new_link;
    logic [1:0]      w_new_speed;
    logic            w_new_duplex;
    logic            w_status_change;

`ifdef MDIO_PHY_INIT_EN
    logic            r_init_done;
    logic            r_cmd_write;
    logic [15:0]     r_cmd_wdata;
    logic            w_unused;

    assign w_init_done = r_init_done;
    assign w_init_end  = (r_state == S_INIT_WAIT) && (rsp_valid || w_wait_expired);
    assign cmd_write   = r_cmd_write;
    assign cmd_wdata   = r_cmd_wdata;
    assign w_unused    = ^{rsp_rdata[12], rsp_rdata[10:3], rsp_rdata[1:0]};
`else
    logic            w_unused;

    assign w_init_done = 1'b1;
    assign w_init_end  = 1'b0;
    assign cmd_write   = 1'b0;
    assign cmd_wdata   = 16'h0000;
    assign w_unused    = ^{rsp_rdata[12], rsp_rdata[10:3], rsp_rdata[1:0], INIT_BMCR};
`endif

    assign w_wait_expired = (r_wait_cnt == c_TO_LAST);
    assign w_poll_start   = (r_state == S_IDLE) && w_init_done &&
                            (((r_interval == '0) && enable) || r_poll_pending);

    // New status from the captured registers; unresolved or reserved speed keeps the old speed/duplex
    always_comb begin
        w_new_link   = r_bmsr_link;
        w_new_speed  = r_speed;
        w_new_duplex = r_full_duplex;
        if (r_pssr_usable) begin
            w_new_speed  = r_pssr_speed;
            w_new_duplex = r_pssr_duplex;
        end
        w_status_change = (w_new_link != r_link_up) ||
                          (w_new_link && ((w_new_speed != r_speed) || (w_new_duplex != r_full_duplex)));
    end

    // Poll sequencer, interval timer, response timeout and registered status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_interval     <= '0;
            r_wait_cnt     <= '0;
            r_poll_pending <= 1'b0;
            r_cmd_valid    <= 1'b0;
            r_cmd_phyaddr  <= 5'd0;
            r_cmd_regaddr  <= 5'd0;
            r_bmsr_link    <= 1'b0;
            r_pssr_usable  <= 1'b0;
            r_pssr_speed   <= 2'b00;
            r_pssr_duplex  <= 1'b0;
            r_link_up      <= 1'b0;
            r_speed        <= 2'b00;
            r_full_duplex  <= 1'b0;
            r_status_valid <= 1'b0;
            r_link_change  <= 1'b0;
            r_timeout_err  <= 1'b0;
`ifdef MDIO_PHY_INIT_EN
            r_init_done    <= 1'b0;
            r_cmd_write    <= 1'b0;
            r_cmd_wdata    <= 16'h0000;
`endif
        end else begin
            r_link_change  <= 1'b0;
            r_timeout_err  <= 1'b0;
            // A request arriving on the very cycle a poll starts stays pending for another poll
            r_poll_pending <= poll_now | (r_poll_pending & ~w_poll_start);

            // Timer runs through the poll itself so poll starts are POLL_INTERVAL apart
            if (w_poll_start || w_init_end) begin
                r_interval <= c_RELOAD;
            end else if (enable && (r_interval != '0)) begin
                r_interval <= r_interval - c_IW'(1);
            end

            case (r_state)
                S_IDLE: begin
`ifdef MDIO_PHY_INIT_EN
                    if (!r_init_done) begin
                        r_state       <= S_INIT_REQ;
                        r_cmd_valid   <= 1'b1;
                        r_cmd_write   <= 1'b1;
                        r_cmd_phyaddr <= PHY_ADDR;
                        r_cmd_regaddr <= 5'd0;
                        r_cmd_wdata   <= INIT_BMCR;
                    end else
`endif
                    if (w_poll_start) begin
                        r_state       <= S_BMSR_REQ;
                        r_cmd_valid   <= 1'b1;
                        r_cmd_phyaddr <= PHY_ADDR;
                        r_cmd_regaddr <= c_BMSR_ADDR;
`ifdef MDIO_PHY_INIT_EN
                        r_cmd_write   <= 1'b0;
                        r_cmd_wdata   <= 16'h0000;
`endif
                    end
                end
`ifdef MDIO_PHY_INIT_EN
                S_INIT_REQ: begin
                    if (cmd_ready) begin
                        r_state     <= S_INIT_WAIT;
                        r_cmd_valid <= 1'b0;
                        r_wait_cnt  <= '0;
                    end
                end
                S_INIT_WAIT: begin
                    if (rsp_valid || w_wait_expired) begin
                        r_state       <= S_IDLE;
                        r_init_done   <= 1'b1;
                        r_timeout_err <= ~rsp_valid;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_TW'(1);
                    end
                end
`endif
                S_BMSR_REQ: begin
                    if (cmd_ready) begin
                        r_state     <= S_BMSR_WAIT;
                        r_cmd_valid <= 1'b0;
                        r_wait_cnt  <= '0;
                    end
                end
                S_BMSR_WAIT: begin
                    if (rsp_valid) begin
                        r_bmsr_link   <= rsp_rdata[2];
                        r_state       <= S_PSSR_REQ;
                        r_cmd_valid   <= 1'b1;
                        r_cmd_regaddr <= PSSR_ADDR;
                    end else if (w_wait_expired) begin
                        r_state       <= S_IDLE;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_TW'(1);
                    end
                end
                S_PSSR_REQ: begin
                    if (cmd_ready) begin
                        r_state     <= S_PSSR_WAIT;
                        r_cmd_valid <= 1'b0;
                        r_wait_cnt  <= '0;
                    end
                end
                S_PSSR_WAIT: begin
                    if (rsp_valid) begin
                        r_pssr_usable <= rsp_rdata[11] && (rsp_rdata[15:14] != 2'b11);
                        r_pssr_speed  <= rsp_rdata[15:14];
                        r_pssr_duplex <= rsp_rdata[13];
                        r_state       <= S_UPDATE;
                    end else if (w_wait_expired) begin
                        r_state       <= S_IDLE;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_TW'(1);
                    end
                end
                S_UPDATE: begin
                    r_link_up      <= w_new_link;
                    r_speed        <= w_new_speed;
                    r_full_duplex  <= w_new_duplex;
                    r_status_valid <= 1'b1;
                    r_link_change  <= w_status_change;
                    r_state        <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid    = r_cmd_valid;
    assign cmd_phyaddr  = r_cmd_phyaddr;
    assign cmd_regaddr  = r_cmd_regaddr;
    assign link_up      = r_link_up;
    assign speed        = r_speed;
    assign full_duplex  = r_full_duplex;
    assign status_valid = r_status_valid;
    assign link_change  = r_link_change;
    assign timeout_err  = r_timeout_err;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
